// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the RAM port arbiter and the async SRAM.
// The slave modport is the arbiter's view of the bundle; the master modport is the view of the requesters and the SRAM.
interface ram_port_arbiter_if;
    logic [21:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_byte_op;
    logic        cpu_wr_inhibit;
    logic        cpu_ack;

    logic [21:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [15:0] dma_rdata;
    logic        dma_rd;
    logic        dma_wr;
    logic        dma_byte_op;
    logic        dma_ack;

    logic [21:0] ram_addr;
    logic [15:0] ram_data_out;
    logic [15:0] ram_data_in;
    logic        ram_rd;
    logic        ram_wr;
    logic        ram_byte_op;
    logic        dma_granted;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, cpu_byte_op, cpu_wr_inhibit,
        output cpu_rdata, cpu_ack,
        input  dma_addr, dma_wdata, dma_rd, dma_wr, dma_byte_op,
        output dma_rdata, dma_ack,
        output ram_addr, ram_data_out, ram_rd, ram_wr, ram_byte_op, dma_granted,
        input  ram_data_in
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, cpu_byte_op, cpu_wr_inhibit,
        input  cpu_rdata, cpu_ack,
        output dma_addr, dma_wdata, dma_rd, dma_wr, dma_byte_op,
        input  dma_rdata, dma_ack,
        input  ram_addr, ram_data_out, ram_rd, ram_wr, ram_byte_op, dma_granted,
        output ram_data_in
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one async-SRAM port between the CPU bus and a DMA requester.
// DMA has priority, but a burst limit guarantees that a waiting CPU is served.
//
// state  | meaning
// IDLE   | sample requests, pick the winner, load the access registers
// ACCESS | hold the strobe for WAIT_CYCLES+1 cycles, latch read data on the last cycle
// DONE   | one-cycle ack to the owner, RAM outputs cleared
module ram_port_arbiter #(
    parameter int WAIT_CYCLES   = 1,
    parameter int MAX_DMA_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [3:0] MAX_BURST = 4'(MAX_DMA_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  burst_cnt;
    logic        owner_dma;
    logic        acc_rd;

    logic        cpu_pend, dma_pend;
    logic        grant_dma, grant_cpu;
    logic        grant_rd, grant_wr, grant_byte;
    logic [21:0] grant_addr;
    logic [15:0] grant_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        cpu_pend    = bus.cpu_rd | bus.cpu_wr;
        dma_pend    = bus.dma_rd | bus.dma_wr;
        grant_dma   = 1'b0;
        grant_cpu   = 1'b0;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        grant_byte  = 1'b0;
        grant_addr  = '0;
        grant_wdata = '0;
        state_next  = state;

        case (state)
            IDLE: begin
                grant_dma = dma_pend && (!cpu_pend || (burst_cnt < MAX_BURST));
                grant_cpu = cpu_pend && !grant_dma;
                if (grant_dma) begin
                    grant_rd    = bus.dma_rd;
                    grant_wr    = bus.dma_wr & ~bus.dma_rd;
                    grant_byte  = bus.dma_byte_op;
                    grant_addr  = bus.dma_addr;
                    grant_wdata = bus.dma_wdata;
                end else if (grant_cpu) begin
                    // an inhibited write still runs its full access, just without the strobe
                    grant_rd    = bus.cpu_rd;
                    grant_wr    = bus.cpu_wr & ~bus.cpu_rd & ~bus.cpu_wr_inhibit;
                    grant_byte  = bus.cpu_byte_op;
                    grant_addr  = bus.cpu_addr;
                    grant_wdata = bus.cpu_wdata;
                end
                if (grant_dma || grant_cpu) state_next = ACCESS;
            end
            ACCESS: if (wait_cnt == 4'd0) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt         <= '0;
            burst_cnt        <= '0;
            owner_dma        <= 1'b0;
            acc_rd           <= 1'b0;
            bus.ram_addr     <= '0;
            bus.ram_data_out <= '0;
            bus.ram_rd       <= 1'b0;
            bus.ram_wr       <= 1'b0;
            bus.ram_byte_op  <= 1'b0;
            bus.cpu_rdata    <= '0;
            bus.dma_rdata    <= '0;
            bus.cpu_ack      <= 1'b0;
            bus.dma_ack      <= 1'b0;
            bus.dma_granted  <= 1'b0;
        end else begin
            bus.cpu_ack <= 1'b0;
            bus.dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dma || grant_cpu) begin
                        wait_cnt         <= WAIT_LOAD;
                        owner_dma        <= grant_dma;
                        acc_rd           <= grant_rd;
                        bus.ram_addr     <= grant_addr;
                        bus.ram_data_out <= grant_wdata;
                        bus.ram_rd       <= grant_rd;
                        bus.ram_wr       <= grant_wr;
                        bus.ram_byte_op  <= grant_byte;
                        bus.dma_granted  <= grant_dma;
                    end
                    if (grant_dma) begin
                        if (burst_cnt != MAX_BURST) burst_cnt <= burst_cnt + 4'd1;
                    end else if (grant_cpu || !dma_pend) begin
                        burst_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (acc_rd) begin
                            if (owner_dma) bus.dma_rdata <= bus.ram_data_in;
                            else           bus.cpu_rdata <= bus.ram_data_in;
                        end
                        if (owner_dma) bus.dma_ack <= 1'b1;
                        else           bus.cpu_ack <= 1'b1;
                        bus.ram_addr     <= '0;
                        bus.ram_data_out <= '0;
                        bus.ram_rd       <= 1'b0;
                        bus.ram_wr       <= 1'b0;
                        bus.ram_byte_op  <= 1'b0;
                    end
                end
                DONE: bus.dma_granted <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with WAIT_CYCLES=1, MAX_DMA_BURST=4.
// Cycle n means the n-th clock period after the IDLE cycle in which a request is first seen.
module tb_ram_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   wr_cycles;
    int   cpu_acks;
    int   dma_acks;
    int   snap_wr, snap_cpu, snap_dma;

    ram_port_arbiter_if bus_if ();

    ram_port_arbiter #(.WAIT_CYCLES(1), .MAX_DMA_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_if.ram_wr)  wr_cycles <= wr_cycles + 1;
        if (bus_if.cpu_ack) cpu_acks  <= cpu_acks + 1;
        if (bus_if.dma_ack) dma_acks  <= dma_acks + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_addr"}, 32'(bus_if.ram_addr), 32'd0);
        chk({tag, "_ram_dout"}, 32'(bus_if.ram_data_out), 32'd0);
        chk({tag, "_strobes"}, {29'd0, bus_if.ram_rd, bus_if.ram_wr, bus_if.ram_byte_op}, 32'd0);
        chk({tag, "_acks"}, {29'd0, bus_if.cpu_ack, bus_if.dma_ack, bus_if.dma_granted}, 32'd0);
        chk({tag, "_cpu_rdata"}, 32'(bus_if.cpu_rdata), 32'd0);
        chk({tag, "_dma_rdata"}, 32'(bus_if.dma_rdata), 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        wr_cycles = 0; cpu_acks = 0; dma_acks = 0;
        reset = 1'b1;
        bus_if.cpu_addr = '0; bus_if.cpu_wdata = '0; bus_if.cpu_rd = 0; bus_if.cpu_wr = 0;
        bus_if.cpu_byte_op = 0; bus_if.cpu_wr_inhibit = 0;
        bus_if.dma_addr = '0; bus_if.dma_wdata = '0; bus_if.dma_rd = 0; bus_if.dma_wr = 0;
        bus_if.dma_byte_op = 0; bus_if.ram_data_in = '0;
        #2 reset = 1'b0;
        #1 chk_all_zero("reset");
        #19 reset = 1'b1;
        step();

        // CPU read alone
        snap_dma = dma_acks;
        bus_if.cpu_addr = 22'o173000; bus_if.cpu_rd = 1; bus_if.ram_data_in = 16'o012706;
        step();
        chk("t1_c1_rd", 32'(bus_if.ram_rd), 32'd1);
        chk("t1_c1_addr", 32'(bus_if.ram_addr), 32'o173000);
        step();
        chk("t1_c2_rd", 32'(bus_if.ram_rd), 32'd1);
        chk("t1_c2_ack", 32'(bus_if.cpu_ack), 32'd0);
        step();
        chk("t1_c3_ack", 32'(bus_if.cpu_ack), 32'd1);
        chk("t1_c3_rdata", 32'(bus_if.cpu_rdata), 32'o012706);
        chk("t1_c3_rd", 32'(bus_if.ram_rd), 32'd0);
        chk("t1_c3_addr", 32'(bus_if.ram_addr), 32'd0);
        step();
        bus_if.cpu_rd = 0;
        chk("t1_c4_ack", 32'(bus_if.cpu_ack), 32'd0);
        chk("t1_no_dma_ack", 32'(dma_acks - snap_dma), 32'd0);

        // simultaneous writes: DMA first, then CPU
        bus_if.cpu_addr = 22'h000100; bus_if.cpu_wdata = 16'h1111; bus_if.cpu_wr = 1;
        bus_if.dma_addr = 22'h000200; bus_if.dma_wdata = 16'h2222; bus_if.dma_wr = 1;
        step();
        chk("t2_c1_wr", 32'(bus_if.ram_wr), 32'd1);
        chk("t2_c1_addr", 32'(bus_if.ram_addr), 32'h200);
        chk("t2_c1_data", 32'(bus_if.ram_data_out), 32'h2222);
        chk("t2_c1_granted", 32'(bus_if.dma_granted), 32'd1);
        step();
        chk("t2_c2_wr", 32'(bus_if.ram_wr), 32'd1);
        step();
        chk("t2_c3_dma_ack", {30'd0, bus_if.dma_ack, bus_if.cpu_ack}, 32'b10);
        chk("t2_c3_granted", 32'(bus_if.dma_granted), 32'd1);
        step();
        bus_if.dma_wr = 0;
        chk("t2_c4_granted", 32'(bus_if.dma_granted), 32'd0);
        step();
        chk("t2_c5_wr", 32'(bus_if.ram_wr), 32'd1);
        chk("t2_c5_addr", 32'(bus_if.ram_addr), 32'h100);
        chk("t2_c5_data", 32'(bus_if.ram_data_out), 32'h1111);
        chk("t2_c5_granted", 32'(bus_if.dma_granted), 32'd0);
        step();
        step();
        chk("t2_c7_cpu_ack", {30'd0, bus_if.dma_ack, bus_if.cpu_ack}, 32'b01);
        chk("t2_c7_rdata_kept", 32'(bus_if.cpu_rdata), 32'o012706);
        step();
        bus_if.cpu_wr = 0;

        // DMA burst limit against a pending CPU
        bus_if.ram_data_in = 16'h5a5a;
        bus_if.dma_addr = 22'h000300; bus_if.dma_rd = 1;
        bus_if.cpu_addr = 22'h000400; bus_if.cpu_rd = 1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 20) bus_if.cpu_rd = 0;
            if (c == 21) bus_if.cpu_rd = 1;
            chk($sformatf("t3_c%0d_dma_ack", c), 32'(bus_if.dma_ack),
                32'(c == 3 || c == 7 || c == 11 || c == 15 || c == 23 || c == 27 || c == 31 || c == 35));
            chk($sformatf("t3_c%0d_cpu_ack", c), 32'(bus_if.cpu_ack), 32'(c == 19 || c == 39));
        end
        bus_if.dma_rd = 0; bus_if.cpu_rd = 0;
        chk("t3_dma_rdata", 32'(bus_if.dma_rdata), 32'h5a5a);
        chk("t3_cpu_rdata", 32'(bus_if.cpu_rdata), 32'h5a5a);

        // inhibited CPU write
        snap_wr = wr_cycles;
        bus_if.cpu_addr = 22'h000500; bus_if.cpu_wdata = 16'hdead;
        bus_if.cpu_wr = 1; bus_if.cpu_wr_inhibit = 1;
        step();
        bus_if.cpu_wr_inhibit = 0;
        chk("t4_c1_wr", 32'(bus_if.ram_wr), 32'd0);
        step();
        chk("t4_c2_wr", 32'(bus_if.ram_wr), 32'd0);
        step();
        chk("t4_c3_ack", 32'(bus_if.cpu_ack), 32'd1);
        step();
        bus_if.cpu_wr = 0;
        chk("t4_no_wr_cycles", 32'(wr_cycles - snap_wr), 32'd0);
        chk("t4_rdata_kept", 32'(bus_if.cpu_rdata), 32'h5a5a);

        // reset during a DMA read access
        snap_dma = dma_acks;
        bus_if.dma_addr = 22'h000600; bus_if.dma_rd = 1; bus_if.ram_data_in = 16'h1234;
        step();
        chk("t5_c1_rd", 32'(bus_if.ram_rd), 32'd1);
        chk("t5_c1_granted", 32'(bus_if.dma_granted), 32'd1);
        #3 reset = 1'b0;
        #1 chk_all_zero("t5_async");
        step();
        chk("t5_held_rd", 32'(bus_if.ram_rd), 32'd0);
        #3 reset = 1'b1;
        step();
        chk("t5_r1_rd", 32'(bus_if.ram_rd), 32'd1);
        chk("t5_r1_addr", 32'(bus_if.ram_addr), 32'h600);
        step();
        chk("t5_r2_rd", 32'(bus_if.ram_rd), 32'd1);
        chk("t5_r2_ack", 32'(bus_if.dma_ack), 32'd0);
        step();
        chk("t5_r3_ack", 32'(bus_if.dma_ack), 32'd1);
        chk("t5_r3_rdata", 32'(bus_if.dma_rdata), 32'h1234);
        step();
        bus_if.dma_rd = 0;
        chk("t5_one_ack", 32'(dma_acks - snap_dma), 32'd1);

        // rd and wr together with a byte op read
        bus_if.cpu_addr = 22'h000700; bus_if.cpu_wdata = 16'h7777;
        bus_if.cpu_rd = 1; bus_if.cpu_wr = 1; bus_if.cpu_byte_op = 1;
        bus_if.ram_data_in = 16'hbeef;
        step();
        chk("t6_c1_strobes", {29'd0, bus_if.ram_rd, bus_if.ram_wr, bus_if.ram_byte_op}, 32'b101);
        step();
        step();
        chk("t6_c3_ack", 32'(bus_if.cpu_ack), 32'd1);
        chk("t6_c3_rdata", 32'(bus_if.cpu_rdata), 32'hbeef);
        step();
        bus_if.cpu_rd = 0; bus_if.cpu_wr = 0; bus_if.cpu_byte_op = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single async-SRAM port (ram_async) between the CPU-side bus and a DMA requester (RK disk model).
- Sequences each access over a fixed number of wait cycles, latches read data and returns a one-cycle ack to the winning requester.
- Uses DMA priority with a burst limit so the CPU cannot be starved.
- Sits between bus/DMA masters and ram_async, in the clk domain.

Parameters:
- WAIT_CYCLES, 1, extra cycles ram_rd/ram_wr are held beyond the first access cycle (1..15).
- MAX_DMA_BURST, 4, consecutive DMA grants allowed while the CPU is pending (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_addr  in  22  CPU physical address
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  CPU read data (registered)
- cpu_rd / cpu_wr  in  1  CPU request, level, held until ack
- cpu_byte_op  in  1  CPU byte access
- cpu_wr_inhibit  in  1  MMU write inhibit, sampled at grant
- cpu_ack  out  1  one-cycle completion pulse
- dma_addr  in  22  DMA address
- dma_wdata  in  16  DMA write data
- dma_rdata  out  16  DMA read data (registered)
- dma_rd / dma_wr  in  1  DMA request, level
- dma_byte_op  in  1  DMA byte access
- dma_ack  out  1  one-cycle completion pulse
- ram_addr  out  22  to ram_async
- ram_data_out  out  16  write data to ram_async
- ram_data_in  in  16  read data from ram_async
- ram_rd / ram_wr  out  1  strobes to ram_async
- ram_byte_op  out  1  to ram_async
- dma_granted  out  1  high while a DMA access is in progress (status/LED)

Behaviour:
- Reset (reset low, async):
  - state=IDLE; burst counter=0; wait counter=0.
  - All outputs 0, including cpu_rdata and dma_rdata.
  - An access in flight is aborted with no ack; the deasserting edge starts from IDLE.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE. A requester is "pending" if rd|wr is high.
  - If both rd and wr are high, it is treated as a read.
  - Winner:
    - DMA if DMA is pending and (CPU is not pending or burst<MAX_DMA_BURST).
    - Otherwise CPU if pending.
  - On a grant, at the next edge:
    - Register addr, byte_op, wdata and the rd/wr type into the ram_* outputs.
    - Register the owner.
    - Load the wait counter with WAIT_CYCLES.
    - Enter ACCESS.
  - Burst counter:
    - A DMA grant increments it, saturating at MAX_DMA_BURST.
    - A CPU grant clears it.
    - IDLE with no DMA pending clears it.
- ACCESS:
  - ram_rd or ram_wr is held high for WAIT_CYCLES+1 cycles; ram_addr, ram_byte_op and ram_data_out are stable throughout.
  - CPU write with cpu_wr_inhibit high at grant: ram_wr stays 0 for the whole access, and the access still completes and acks.
  - On the last ACCESS cycle (counter==0), a read latches ram_data_in into the owner's rdata at the edge. The next state is DONE.
- DONE:
  - Owner's ack=1 for exactly one cycle.
  - ram_rd=ram_wr=0; ram_addr, ram_byte_op and ram_data_out return to 0.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle 0, ack high in cycle WAIT_CYCLES+2 (3 for the default).
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Requesters deassert rd/wr in the cycle after they sample ack. A request still high during DONE is not double-counted, because sampling happens only in IDLE.
- rdata is held until the owner's next completed read; writes never change rdata.
- Input changes by a requester during ACCESS are ignored.
- A requester dropping its request mid-ACCESS does not abort the access; the ack is still issued.
- dma_granted=1 in ACCESS and DONE when the owner is DMA.

Test Plan:
- CPU read alone, WAIT_CYCLES=1: cpu_addr=22'o173000, ram_data_in=16'o012706 → ram_rd high cycles 1-2, cpu_ack in cycle 3, cpu_rdata=16'o012706, dma_ack never pulses.
- Simultaneous CPU and DMA write in the same cycle → DMA served first (ram_wr with dma_addr/dma_wdata), then CPU. Acks are 4 cycles apart, in order dma then cpu.
- DMA continuously requesting, CPU pending, MAX_DMA_BURST=4 → exactly 4 DMA acks, then 1 CPU ack, then DMA resumes, with the burst count restarting at 0.
- CPU write with cpu_wr_inhibit=1 → ram_wr stays 0 throughout, cpu_ack still pulses in cycle 3, and RAM contents are unchanged.
- Assert reset low during ACCESS of a DMA read → all outputs 0 immediately, no dma_ack. After release, a still-pending DMA request is re-granted from IDLE with a full WAIT_CYCLES+1 strobe.
- cpu_rd and cpu_wr both high, byte_op=1 → treated as a read: ram_rd=1, ram_wr=0, ram_byte_op=1, ack normal.
